srff_cmd_seq: RTL and testbench

Command sequencer that drives a bank of N SR flip-flops to a requested target vector. It generates the `s`/`r` excitation pulses, one channel at a time, and never asserts `s` and `r` together on any channel. It keeps a shadow copy of the flip-flop state so that only channels that differ are pulsed. It sits upstream of the SR flip-flop bank, whose flip-flops reset to `q=0`.

---
 rtl/srff_pkg.sv | 22 ++
 rtl/srff_cmd_seq_lsb_prio_enc.sv | 32 +++
 rtl/srff_cmd_seq.sv | 178 +++++++++++++++++
 tb/tb_srff_cmd_seq.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/srff_pkg.sv
`default_nettype none
// ============================================================================
// Module   : srff_pkg
// Purpose  : Shared types and constants for the SR flip-flop command sequencer.
//            - srff_seq_state_t : sequencer FSM state encoding
//            - SRFF_RST_Q       : reset value of the downstream SR flip-flops,
//                                 which the sequencer's shadow copy mirrors
// Revision : 1.0 - initial release
// ============================================================================
package srff_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEL  = 2'd1,
        S_HOLD = 2'd2,
        S_DONE = 2'd3
    } srff_seq_state_t;

    localparam logic SRFF_RST_Q = 1'b0;

endpackage : srff_pkg
`default_nettype wire

// File: rtl/srff_cmd_seq_lsb_prio_enc.sv
`default_nettype none
// ============================================================================
// Module   : lsb_prio_enc
// Purpose  : Purely combinational lowest-set-bit priority encoder.
// Ports    : pending_i [N-1:0]  - request vector
//            sel_o     [SW-1:0] - index of the lowest set bit (0 if none)
//            found_o            - high when any bit of pending_i is set
// Revision : 1.0 - initial release
// ============================================================================
module lsb_prio_enc #(
    parameter  int N  = 8,
    localparam int SW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  pending_i,
    output logic [SW-1:0] sel_o,
    output logic          found_o
);

    // Scan from the top down so the last hit written is the lowest index.
    always_comb begin
        sel_o   = '0;
        found_o = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (pending_i[i]) begin
                sel_o   = SW'(i);
                found_o = 1'b1;
            end
        end
    end

endmodule : lsb_prio_enc
`default_nettype wire

// File: rtl/srff_cmd_seq.sv
`default_nettype none
// ============================================================================
// Module   : srff_cmd_seq
// Purpose  : Drives a bank of N SR flip-flops to a requested target vector by
//            issuing one s/r pulse at a time (ascending channel order), each
//            HOLD cycles long and separated by at least one idle gap cycle.
//            A shadow copy of the bank state limits pulses to channels that
//            actually differ.
// Ports    : clk        - rising-edge clock
//            rst        - asynchronous, active-low reset
//            tgt_valid  - target offered          tgt_ready - target accepted
//            tgt  [N]   - target bank state       abort     - cancel sequence
//            s    [N]   - set pulses (registered) r   [N]   - reset pulses
//            shadow [N] - modelled bank state     busy      - not idle
//            done       - one-cycle completion pulse (not raised on abort)
// Revision : 1.0 - initial release
// ============================================================================
module srff_cmd_seq
    import srff_pkg::*;
#(
    parameter int N    = 8,
    parameter int HOLD = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         tgt_valid,
    output logic         tgt_ready,
    input  logic [N-1:0] tgt,
    input  logic         abort,
    output logic [N-1:0] s,
    output logic [N-1:0] r,
    output logic [N-1:0] shadow,
    output logic         busy,
    output logic         done
);

    localparam int             CW       = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam int             SW       = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0]  CNT_LOAD = CW'(HOLD - 1);

    srff_seq_state_t state_q, state_d;

    logic [N-1:0]  tgt_q;
    logic [N-1:0]  pending_q;
    logic [N-1:0]  shadow_q;
    logic [N-1:0]  s_q;
    logic [N-1:0]  r_q;
    logic [CW-1:0] cnt_q;

    logic [SW-1:0] sel;
    logic          found;
    logic [N-1:0]  sel_onehot;

    // pending_q is frozen while a pulse is held, so the encoder output stays
    // valid through the whole HOLD phase and needs no separate register.
    lsb_prio_enc #(
        .N (N)
    ) u_prio_enc (
        .pending_i (pending_q),
        .sel_o     (sel),
        .found_o   (found)
    );

    always_comb begin
        sel_onehot      = '0;
        sel_onehot[sel] = 1'b1;
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (tgt_valid) begin
                    state_d = S_SEL;
                end
            end
            S_SEL: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (!found) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (cnt_q == '0) begin
                    state_d = S_SEL;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: target latch, pending mask, pulse registers, shadow
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tgt_q     <= '0;
            pending_q <= '0;
            shadow_q  <= {N{SRFF_RST_Q}};
            s_q       <= '0;
            r_q       <= '0;
            cnt_q     <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (tgt_valid) begin
                        tgt_q     <= tgt;
                        pending_q <= tgt ^ shadow_q;
                    end
                end
                S_SEL: begin
                    // s/r are already zero here; this cycle is the gap.
                    if (!abort && found) begin
                        s_q   <= sel_onehot & tgt_q;
                        r_q   <= sel_onehot & ~tgt_q;
                        cnt_q <= CNT_LOAD;
                    end
                end
                S_HOLD: begin
                    if (abort) begin
                        // Interrupted channel is left out of the shadow.
                        s_q <= '0;
                        r_q <= '0;
                    end else if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CW'(1);
                    end else begin
                        s_q            <= '0;
                        r_q            <= '0;
                        shadow_q[sel]  <= tgt_q[sel];
                        pending_q[sel] <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------
    always_comb begin
        tgt_ready = (state_q == S_IDLE);
        busy      = (state_q != S_IDLE);
        // An abort arriving in DONE suppresses the completion pulse.
        done      = (state_q == S_DONE) && !abort;
    end

    assign s      = s_q;
    assign r      = r_q;
    assign shadow = shadow_q;

endmodule : srff_cmd_seq
`default_nettype wire

// File: tb/tb_srff_cmd_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_srff_cmd_seq
// Purpose  : Self-checking bench for srff_cmd_seq. Three instances (HOLD=1,2,3,
//            N=8) share clock and reset. A behavioural model expands each
//            target into the expected per-cycle trace of s/r/shadow/done/busy/
//            tgt_ready, which is compared every cycle.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_srff_cmd_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       tv  [3];
    logic [7:0] tg  [3];
    logic       ab  [3];
    logic       rdy [3];
    logic       bsy [3];
    logic       dn  [3];
    logic [7:0] so  [3];
    logic [7:0] ro  [3];
    logic [7:0] sh  [3];

    int checks = 0;
    int errors = 0;

    logic [7:0] mshadow [3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        srff_cmd_seq #(
            .N    (8),
            .HOLD (g + 1)
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .tgt_valid (tv[g]),
            .tgt_ready (rdy[g]),
            .tgt       (tg[g]),
            .abort     (ab[g]),
            .s         (so[g]),
            .r         (ro[g]),
            .shadow    (sh[g]),
            .busy      (bsy[g]),
            .done      (dn[g])
        );
    end

    typedef struct packed {
        logic [7:0] s;
        logic [7:0] r;
        logic [7:0] sh;
        logic       dn;
        logic       bsy;
        logic       rdy;
    } cyc_t;

    cyc_t exp_q[$];

    // Invariant on every instance in every cycle: no s&r overlap, at most one
    // channel active.
    always @(negedge clk) begin
        for (int g = 0; g < 3; g++) begin
            checks++;
            if (((so[g] & ro[g]) !== 8'h00) || !$onehot0(so[g] | ro[g])) begin
                errors++;
                $display("FAIL invariant inst=%0d s=%h r=%h (need s&r==0, onehot0)",
                         g, so[g], ro[g]);
            end
        end
    end

    // Expected trace, one entry per cycle starting with the cycle after the
    // accepting edge: gap, then per differing channel (ascending) HOLD pulse
    // cycles and a gap showing the updated shadow, then the done cycle, then
    // one idle cycle. An abort during cycle A truncates after A and the
    // following idle cycle keeps whatever shadow cycle A already showed.
    task automatic model_build(input int hold, input logic [7:0] t,
                               input logic [7:0] sh0, input int acyc);
        logic [7:0] shm;
        logic [7:0] one;
        cyc_t       e;
        exp_q.delete();
        shm = sh0;
        e = '{s: 8'h00, r: 8'h00, sh: shm, dn: 1'b0, bsy: 1'b1, rdy: 1'b0};
        exp_q.push_back(e);
        for (int i = 0; i < 8; i++) begin
            if (t[i] != shm[i]) begin
                one = 8'h01 << i;
                for (int k = 0; k < hold; k++) begin
                    e = '{s: (t[i] ? one : 8'h00), r: (t[i] ? 8'h00 : one),
                          sh: shm, dn: 1'b0, bsy: 1'b1, rdy: 1'b0};
                    exp_q.push_back(e);
                end
                shm[i] = t[i];
                e = '{s: 8'h00, r: 8'h00, sh: shm, dn: 1'b0, bsy: 1'b1, rdy: 1'b0};
                exp_q.push_back(e);
            end
        end
        e = '{s: 8'h00, r: 8'h00, sh: shm, dn: 1'b1, bsy: 1'b1, rdy: 1'b0};
        exp_q.push_back(e);
        if (acyc > 0) begin
            while (exp_q.size() > acyc) void'(exp_q.pop_back());
            shm = exp_q[acyc-1].sh;
        end
        e = '{s: 8'h00, r: 8'h00, sh: shm, dn: 1'b0, bsy: 1'b0, rdy: 1'b1};
        exp_q.push_back(e);
    endtask

    // Offers a target to instance h (must be called at a negedge while idle)
    // and compares every following cycle against the model trace.
    task automatic run_seq(input int h, input logic [7:0] t, input int acyc,
                           input logic ab_accept, output int done_at,
                           output int ready_at);
        cyc_t e;
        cyc_t act;
        model_build(h + 1, t, mshadow[h], acyc);
        done_at  = -1;
        ready_at = -1;
        tv[h] = 1'b1;
        tg[h] = t;
        ab[h] = ab_accept;
        @(negedge clk);
        tv[h] = 1'b0;
        ab[h] = 1'b0;
        tg[h] = 8'($urandom);
        for (int c = 1; c <= exp_q.size(); c++) begin
            e   = exp_q[c-1];
            act = '{s: so[h], r: ro[h], sh: sh[h], dn: dn[h], bsy: bsy[h], rdy: rdy[h]};
            checks++;
            if (act !== e) begin
                errors++;
                $display("FAIL trace inst=%0d tgt=%h cyc=%0d got s=%h r=%h sh=%h dn=%b bsy=%b rdy=%b want s=%h r=%h sh=%h dn=%b bsy=%b rdy=%b",
                         h, t, c, act.s, act.r, act.sh, act.dn, act.bsy, act.rdy,
                         e.s, e.r, e.sh, e.dn, e.bsy, e.rdy);
            end
            if (dn[h] === 1'b1 && done_at < 0) done_at = c;
            if (rdy[h] === 1'b1 && ready_at < 0) ready_at = c;
            ab[h] = (c == acyc);
            @(negedge clk);
        end
        ab[h] = 1'b0;
        mshadow[h] = exp_q[exp_q.size()-1].sh;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        for (int g = 0; g < 3; g++) begin
            tv[g] = 1'b1;
            tg[g] = 8'hFF;
            ab[g] = 1'b0;
            mshadow[g] = 8'h00;
        end
        repeat (3) begin
            @(negedge clk);
            for (int g = 0; g < 3; g++) begin
                checks++;
                if (so[g] !== 8'h00 || ro[g] !== 8'h00 || sh[g] !== 8'h00 ||
                    rdy[g] !== 1'b1 || bsy[g] !== 1'b0 || dn[g] !== 1'b0) begin
                    errors++;
                    $display("FAIL reset_vals inst=%0d got s=%h r=%h sh=%h rdy=%b bsy=%b dn=%b want 00 00 00 1 0 0",
                             g, so[g], ro[g], sh[g], rdy[g], bsy[g], dn[g]);
                end
            end
        end
        for (int g = 0; g < 3; g++) tv[g] = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        for (int g = 0; g < 3; g++) begin
            checks++;
            if (bsy[g] !== 1'b0 || rdy[g] !== 1'b1) begin
                errors++;
                $display("FAIL reset_nothing_accepted inst=%0d got bsy=%b rdy=%b want 0 1",
                         g, bsy[g], rdy[g]);
            end
        end
    endtask

    task automatic test_two_channel();
        int d, rd;
        run_seq(0, 8'h05, 0, 1'b0, d, rd);
        checks++;
        if (d !== 6) begin
            errors++;
            $display("FAIL two_channel_done_cycle got %0d want 6", d);
        end
        checks++;
        if (sh[0] !== 8'h05) begin
            errors++;
            $display("FAIL two_channel_shadow got %h want 05", sh[0]);
        end
    endtask

    task automatic test_mixed();
        int d, rd;
        run_seq(2, 8'h0F, 0, 1'b0, d, rd);
        run_seq(2, 8'h1E, 0, 1'b0, d, rd);
        checks++;
        if (d !== 10) begin
            errors++;
            $display("FAIL mixed_done_cycle got %0d want 10", d);
        end
        checks++;
        if (sh[2] !== 8'h1E) begin
            errors++;
            $display("FAIL mixed_shadow got %h want 1e", sh[2]);
        end
    endtask

    task automatic test_no_change();
        int d, rd;
        run_seq(2, 8'h1E, 0, 1'b0, d, rd);
        checks++;
        if (d !== 2 || rd !== 3) begin
            errors++;
            $display("FAIL no_change_timing got done=%0d ready=%0d want 2 3", d, rd);
        end
    endtask

    task automatic test_abort();
        int d, rd;
        // HOLD=2: bit-0 pulse in cycles 2-3, gap at 4, bit-1 pulse starts at 5.
        run_seq(1, 8'h03, 5, 1'b0, d, rd);
        checks++;
        if (d !== -1) begin
            errors++;
            $display("FAIL abort_no_done got done at cycle %0d want none", d);
        end
        checks++;
        if (rd !== 6 || sh[1] !== 8'h01 || so[1] !== 8'h00) begin
            errors++;
            $display("FAIL abort_state got ready=%0d sh=%h s=%h want 6 01 00",
                     rd, sh[1], so[1]);
        end
    endtask

    task automatic test_async_reset();
        // Instance 2 holds shadow 1e; target 1f needs a 3-cycle set on bit 0.
        tv[2] = 1'b1;
        tg[2] = 8'h1F;
        @(negedge clk);
        tv[2] = 1'b0;
        @(negedge clk);
        checks++;
        if (so[2] !== 8'h01) begin
            errors++;
            $display("FAIL async_pre_pulse got s=%h want 01", so[2]);
        end
        #2 rst = 1'b0;
        #1;
        for (int g = 0; g < 3; g++) begin
            checks++;
            if (so[g] !== 8'h00 || ro[g] !== 8'h00 || sh[g] !== 8'h00 || rdy[g] !== 1'b1) begin
                errors++;
                $display("FAIL async_reset inst=%0d got s=%h r=%h sh=%h rdy=%b want 00 00 00 1",
                         g, so[g], ro[g], sh[g], rdy[g]);
            end
            mshadow[g] = 8'h00;
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_random();
        int h, k, len, acyc, d, rd;
        logic [7:0] t;
        for (int it = 0; it < 40; it++) begin
            h = int'($urandom_range(0, 2));
            t = ($urandom_range(0, 7) == 0) ? mshadow[h] : 8'($urandom);
            k = $countones(t ^ mshadow[h]);
            len = k * (h + 2) + 2;
            acyc = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, len - 1)) : 0;
            run_seq(h, t, acyc, 1'($urandom_range(0, 1)), d, rd);
        end
    endtask

    initial begin
        rst = 1'b0;
        for (int g = 0; g < 3; g++) begin
            tv[g] = 1'b0;
            tg[g] = 8'h00;
            ab[g] = 1'b0;
            mshadow[g] = 8'h00;
        end
        test_reset();
        test_two_channel();
        test_mixed();
        test_no_change();
        test_abort();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_srff_cmd_seq
`default_nettype wire
